// File: rtl/shift_unit_pkg.sv
// Shared types for the shift/rotate unit: operation codes and controller states.
package shift_unit_pkg;

    typedef enum logic [2:0] {
        OP_ROL  = 3'b000,
        OP_ROR  = 3'b001,
        OP_RCL  = 3'b010,
        OP_RCR  = 3'b011,
        OP_SLL  = 3'b100,
        OP_SRL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_LOAD = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; LOAD passes data and carry through.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] data,
    input  logic             carry,
    output logic [WIDTH-1:0] next_data,
    output logic             next_carry
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_data  = data;
        next_carry = carry;
        case (op)
            OP_ROL: begin
                next_data  = {data[WIDTH-2:0], data[WIDTH-1]};
                next_carry = data[WIDTH-1];
            end
            OP_ROR: begin
                next_data  = {data[0], data[WIDTH-1:1]};
                next_carry = data[0];
            end
            OP_RCL: begin
                next_data  = {data[WIDTH-2:0], carry};
                next_carry = data[WIDTH-1];
            end
            OP_RCR: begin
                next_data  = {carry, data[WIDTH-1:1]};
                next_carry = data[0];
            end
            OP_SLL: begin
                next_data  = {data[WIDTH-2:0], 1'b0};
                next_carry = data[WIDTH-1];
            end
            OP_SRL: begin
                next_data  = {1'b0, data[WIDTH-1:1]};
                next_carry = data[0];
            end
            OP_SRA: begin
                next_data  = {data[WIDTH-1], data[WIDTH-1:1]};
                next_carry = data[0];
            end
            default: begin
                next_data  = data;
                next_carry = carry;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-mode shift/rotate unit with start/busy/done handshake, one bit per clock.
// Defining SHIFT_UNIT_FAST_EN computes the whole result in the start cycle instead.
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout
);

    state_t state;
    state_t next_state;
    logic   accept;

    assign accept = (state == ST_IDLE) && start;

`ifdef SHIFT_UNIT_FAST_EN
    // Stage k of the chain holds the operand after k single-bit steps.
    logic [WIDTH-1:0] chain_data  [WIDTH];
    logic             chain_carry [WIDTH];
    logic [WIDTH-1:0] fast_data;
    logic             fast_carry;

    assign chain_data[0]  = din;
    assign chain_carry[0] = cin;

    for (genvar k = 1; k < WIDTH; k++) begin : g_chain
        shift_step #(.WIDTH(WIDTH)) u_step (
            .op         (op_t'(op)),
            .data       (chain_data[k-1]),
            .carry      (chain_carry[k-1]),
            .next_data  (chain_data[k]),
            .next_carry (chain_carry[k])
        );
    end

    always_comb begin
        fast_data  = chain_data[amt];
        fast_carry = chain_carry[amt];
        if (op_t'(op) == OP_LOAD) begin
            fast_data  = din;
            fast_carry = cin;
        end
    end

    assign busy = 1'b0;
`else
    op_t              op_q;
    logic [AW-1:0]    count;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op         (op_q),
        .data       (dout),
        .carry      (cout),
        .next_data  (step_data),
        .next_carry (step_carry)
    );
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef SHIFT_UNIT_FAST_EN
                    next_state = ST_DONE;
`else
                    next_state = (amt == '0 || op_t'(op) == OP_LOAD) ? ST_DONE : ST_SHIFT;
`endif
                end
            end
`ifndef SHIFT_UNIT_FAST_EN
            ST_SHIFT: begin
                if (count == AW'(1)) next_state = ST_DONE;
            end
`endif
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            dout  <= '0;
            cout  <= 1'b0;
`ifndef SHIFT_UNIT_FAST_EN
            busy  <= 1'b0;
            count <= '0;
            op_q  <= OP_ROL;
`endif
        end else begin
            state <= next_state;
            done  <= (next_state == ST_DONE);
`ifdef SHIFT_UNIT_FAST_EN
            if (accept) begin
                dout <= fast_data;
                cout <= fast_carry;
            end
`else
            busy <= (next_state == ST_SHIFT);
            if (accept) begin
                dout  <= din;
                cout  <= cin;
                count <= amt;
                op_q  <= op_t'(op);
            end else if (state == ST_SHIFT) begin
                dout  <= step_data;
                cout  <= step_carry;
                count <= count - AW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=8); honours SHIFT_UNIT_FAST_EN for latency expectations.
module tb_shift_unit;

    localparam int W = 8;
`ifdef SHIFT_UNIT_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] din;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       cout;

    int         errors   = 0;
    int         checks   = 0;
    int         done_cnt = 0;
    logic [7:0] exp_d    = 8'h00;
    logic       exp_c    = 1'b0;
    bit         hold_chk = 1'b0;

    shift_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amt   (amt),
        .din   (din),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Whole-operation result from the arithmetic meaning of each op.
    function automatic void model(input logic [2:0] o, input int n, input logic [7:0] d,
                                  input logic c, output logic [7:0] rd, output logic rc);
        logic [15:0] dd;
        logic [8:0]  x;
        logic [17:0] xx;
        rd = d;
        rc = c;
        x  = {c, d};
        if (o == 3'd7 || n == 0) return;
        case (o)
            3'd0: begin dd = {d, d} << n; rd = dd[15:8]; rc = rd[0]; end
            3'd1: begin dd = {d, d} >> n; rd = dd[7:0];  rc = rd[7]; end
            3'd2: begin xx = {x, x} << n; {rc, rd} = xx[17:9]; end
            3'd3: begin xx = {x, x} >> n; {rc, rd} = xx[8:0]; end
            3'd4: begin rd = d << n; rc = d[8-n]; end
            3'd5: begin rd = d >> n; rc = d[n-1]; end
            default: begin rd = $signed(d) >>> n; rc = d[n-1]; end
        endcase
    endfunction

    // Compare process: result on every done pulse, and held value while idle afterwards.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check("done_dout", dout, exp_d);
                check("done_cout", cout, exp_c);
                hold_chk = 1'b1;
            end else if (hold_chk && !busy) begin
                check("hold_dout", dout, exp_d);
                check("hold_cout", cout, exp_c);
            end
        end
    end

    task automatic run(input string name, input logic [2:0] o, input int n,
                       input logic [7:0] d, input logic c, input bit inj);
        int         idx;
        int         busy_cyc;
        int         dc0;
        int         exp_lat;
        bit         seen;
        logic [7:0] md;
        logic       mc;
        model(o, n, d, c, md, mc);
        exp_lat  = (FAST || n == 0 || o == 3'd7) ? 0 : n;
        hold_chk = 1'b0;
        @(negedge clk);
        exp_d = md;
        exp_c = mc;
        dc0   = done_cnt;
        op    = o;
        amt   = n[2:0];
        din   = d;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        amt   = ~amt;
        din   = ~d;
        cin   = ~c;
        seen     = 1'b0;
        busy_cyc = 0;
        idx      = 0;
        while (!seen && idx < 40) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                check({name, "_latency"}, idx, exp_lat);
                if (inj) start = 1'b1;
            end else begin
                if (inj && idx == 2) start = 1'b1;
                if (inj && idx == 3) start = 1'b0;
                idx++;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_busy_cycles"}, busy_cyc, FAST ? 0 : exp_lat);
        check({name, "_done_pulses"}, done_cnt - dc0, 1);
    endtask

    task automatic lit(input string name, input logic [7:0] ld, input logic lc);
        check({name, "_lit_dout"}, dout, ld);
        check({name, "_lit_cout"}, cout, lc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        amt   = 3'd0;
        din   = 8'h00;
        cin   = 1'b0;
        #12;
        check("reset_dout", dout, 0);
        check("reset_cout", cout, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        run("rol81", 3'd0, 1, 8'h81, 1'b0, 1'b0); lit("rol81", 8'h03, 1'b1);
        run("rcr01", 3'd3, 2, 8'h01, 1'b0, 1'b0); lit("rcr01", 8'h80, 1'b0);
        run("sra90", 3'd6, 3, 8'h90, 1'b0, 1'b0); lit("sra90", 8'hF2, 1'b0);
        run("srl90", 3'd5, 3, 8'h90, 1'b0, 1'b0); lit("srl90", 8'h12, 1'b0);
        run("sllff", 3'd4, 7, 8'hFF, 1'b0, 1'b1); lit("sllff", 8'h80, 1'b1);
        run("load5a", 3'd7, 5, 8'h5A, 1'b1, 1'b0); lit("load5a", 8'h5A, 1'b1);
        run("rcla5", 3'd2, 3, 8'hA5, 1'b1, 1'b0); lit("rcla5", 8'h2E, 1'b1);
        run("ror01", 3'd1, 7, 8'h01, 1'b1, 1'b0); lit("ror01", 8'h02, 1'b0);
        run("sra7f", 3'd6, 7, 8'h7F, 1'b0, 1'b0);
        run("rcr_c1", 3'd3, 4, 8'h3C, 1'b1, 1'b0);
        for (int o = 0; o < 7; o++) begin
            run($sformatf("amt0_op%0d", o), o[2:0], 0, 8'h3C + 8'(o), o[0], 1'b0);
        end
        lit("amt0_last", 8'h42, 1'b0);

        // Asynchronous reset in the middle of a long shift.
        hold_chk = 1'b0;
        @(negedge clk);
        op    = 3'd4;
        amt   = 3'd7;
        din   = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst   = 1'b1;
        exp_d = 8'h00;
        exp_c = 1'b0;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_cout", cout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("postrst_dout", dout, 0);
        run("after_rst", 3'd0, 4, 8'hC3, 1'b0, 1'b0); lit("after_rst", 8'h3C, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
